// File: rtl/solder_chk_settle_timer.sv
// Reloadable down-counter that flags when it has reached zero.
// The solder-check sequencer uses it to hold each test pattern for a fixed settle time.
module solder_chk_settle_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and simulation ordering cannot change the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/solder_chk_ctrl.sv
// Solder-bridge / open-pin check sequencer: walks a one-hot pattern plus an all-zero
// baseline across the pins under test and compares the loop-back pins after a settle time.
module solder_chk_ctrl #(
    parameter int NUM_PINS      = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_PASSES    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    output logic [NUM_PINS-1:0]               test_pins,
    input  logic [NUM_PINS-1:0]               result_pins,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              pass_o,
    output logic                              fail_o,
    output logic [$clog2(NUM_PINS+1)-1:0]     fail_step_o,
    output logic [NUM_PINS-1:0]               fail_bits_o,
    output logic [$clog2(NUM_PASSES+1)-1:0]   pass_cnt_o
);

    localparam int SW = $clog2(NUM_PINS + 1);
    localparam int PW = $clog2(NUM_PASSES + 1);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SW-1:0] LAST_STEP     = SW'(NUM_PINS);
    localparam logic [PW-1:0] LAST_PASS     = PW'(NUM_PASSES - 1);
    localparam logic [PW-1:0] ALL_PASSES    = PW'(NUM_PASSES);
    localparam logic [TW-1:0] SETTLE_RELOAD = TW'(SETTLE_CYCLES - 1);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_DRIVE  = 2'd1;
    localparam state_t S_SAMPLE = 2'd2;
    localparam state_t S_DONE   = 2'd3;

    state_t            state;
    logic [SW-1:0]     step;
    logic [NUM_PINS-1:0] r_res;
    logic [NUM_PINS-1:0] expected;
    logic [NUM_PINS-1:0] next_pattern;
    logic [TW-1:0]     settle_count;
    logic              settle_done;
    logic              start_ok;
    logic              running;
    logic              sample_match;
    logic              run_complete;
    logic              timer_load;

    // Steps below NUM_PINS are one-hot; step NUM_PINS is the all-zero baseline.
    function automatic logic [NUM_PINS-1:0] pattern_for(input logic [SW-1:0] s);
        logic [NUM_PINS-1:0] one_hot;
        one_hot = {{(NUM_PINS-1){1'b0}}, 1'b1};
        return (s < LAST_STEP) ? (one_hot << s) : '0;
    endfunction

    assign expected     = pattern_for(step);
    assign next_pattern = pattern_for(step + SW'(1));
    assign start_ok     = start_i && (state == S_IDLE || state == S_DONE);
    assign running      = (state == S_DRIVE) || (state == S_SAMPLE);
    assign sample_match = (r_res == expected);
    assign run_complete = (step == LAST_STEP) && (pass_cnt_o == LAST_PASS);
    assign timer_load   = start_ok ||
                          (state == S_SAMPLE && !abort_i && sample_match && !run_complete);

    solder_chk_settle_timer #(
        .WIDTH (TW)
    ) u_settle_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (timer_load),
        .load_val (SETTLE_RELOAD),
        .count    (settle_count),
        .done     (settle_done)
    );

    // Loop-back pins are asynchronous to the pattern; one register stage before compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res <= '0;
        end else begin
            r_res <= result_pins;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            step        <= '0;
            test_pins   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_step_o <= '0;
            fail_bits_o <= '0;
            pass_cnt_o  <= '0;
        end else if (running && abort_i) begin
            state       <= S_IDLE;
            step        <= '0;
            test_pins   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_step_o <= '0;
            fail_bits_o <= '0;
            pass_cnt_o  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state       <= S_DRIVE;
                        step        <= '0;
                        test_pins   <= pattern_for('0);
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        pass_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        fail_step_o <= '0;
                        fail_bits_o <= '0;
                        pass_cnt_o  <= '0;
                    end
                end

                S_DRIVE: begin
                    if (settle_done) begin
                        state <= S_SAMPLE;
                    end
                end

                S_SAMPLE: begin
                    if (!sample_match) begin
                        state       <= S_DONE;
                        test_pins   <= '0;
                        busy_o      <= 1'b0;
                        done_o      <= 1'b1;
                        fail_o      <= 1'b1;
                        fail_step_o <= step;
                        fail_bits_o <= r_res ^ expected;
                    end else if (run_complete) begin
                        state      <= S_DONE;
                        test_pins  <= '0;
                        busy_o     <= 1'b0;
                        done_o     <= 1'b1;
                        pass_o     <= 1'b1;
                        pass_cnt_o <= ALL_PASSES;
                    end else if (step == LAST_STEP) begin
                        state      <= S_DRIVE;
                        step       <= '0;
                        test_pins  <= pattern_for('0);
                        pass_cnt_o <= pass_cnt_o + PW'(1);
                    end else begin
                        state     <= S_DRIVE;
                        step      <= step + SW'(1);
                        test_pins <= next_pattern;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solder_chk_ctrl.sv
// Directed bench for solder_chk_ctrl with NUM_PINS=4, SETTLE_CYCLES=2, NUM_PASSES=2.
// Loop-back faults are modelled combinationally from test_pins.
module tb_solder_chk_ctrl;

    localparam int NP  = 4;
    localparam int SC  = 2;
    localparam int NPS = 2;

    typedef enum int {F_NONE, F_STUCK0_P2, F_STUCK1_P3, F_BRIDGE12, F_LATE0} fault_t;

    typedef struct {
        fault_t fault;
        int     done_edge;
        int     pass_v;
        int     fail_v;
        int     step_v;
        int     bits_v;
        int     pcnt_v;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic [NP-1:0] test_pins;
    logic [NP-1:0] result_pins;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic          fail_o;
    logic [2:0]    fail_step_o;
    logic [NP-1:0] fail_bits_o;
    logic [1:0]    pass_cnt_o;

    fault_t fault;
    int     edge_n;
    int     errors = 0;
    int     checks = 0;

    solder_chk_ctrl #(
        .NUM_PINS      (NP),
        .SETTLE_CYCLES (SC),
        .NUM_PASSES    (NPS)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .test_pins   (test_pins),
        .result_pins (result_pins),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .fail_step_o (fail_step_o),
        .fail_bits_o (fail_bits_o),
        .pass_cnt_o  (pass_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge count since the last start pulse, used to switch on late faults.
    always @(posedge clk_i) begin
        if (start_i) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    always_comb begin
        result_pins = test_pins;
        case (fault)
            F_STUCK0_P2: result_pins[2] = 1'b0;
            F_STUCK1_P3: result_pins[3] = 1'b1;
            F_BRIDGE12: begin
                result_pins[1] = test_pins[1] | test_pins[2];
                result_pins[2] = test_pins[1] | test_pins[2];
            end
            F_LATE0: if (edge_n >= 15) result_pins[0] = 1'b0;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_pass"}, 32'(pass_o), 0);
        check({tag, "_fail"}, 32'(fail_o), 0);
        check({tag, "_step"}, 32'(fail_step_o), 0);
        check({tag, "_bits"}, 32'(fail_bits_o), 0);
        check({tag, "_pcnt"}, 32'(pass_cnt_o), 0);
        check({tag, "_pins"}, 32'(test_pins), 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    // Leaves the bench 1 time unit after the start edge (edge 0).
    task automatic start_pulse();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max_edges, output int n);
        n = 0;
        while (!done_o && n < max_edges) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("done_reached", 32'(done_o), 1);
    endtask

    function automatic logic [NP-1:0] exp_pat(input int k);
        int s;
        logic [NP-1:0] one;
        s   = (k / (SC + 1)) % (NP + 1);
        one = 4'b0001;
        return (s < NP) ? (one << s) : '0;
    endfunction

    initial begin
        vec_t vecs[5];
        int   n;

        vecs[0] = '{F_NONE,      30, 1, 0, 0, 4'b0000, 2};
        vecs[1] = '{F_STUCK0_P2,  9, 0, 1, 2, 4'b0100, 0};
        vecs[2] = '{F_STUCK1_P3,  3, 0, 1, 0, 4'b1000, 0};
        vecs[3] = '{F_BRIDGE12,   6, 0, 1, 1, 4'b0100, 0};
        vecs[4] = '{F_LATE0,     18, 0, 1, 0, 4'b0001, 1};

        rst_i   = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        fault   = F_NONE;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_idle("reset");

        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        check_idle("abort_idle");

        for (int i = 0; i < 5; i++) begin
            fault = vecs[i].fault;
            do_reset();
            start_pulse();
            wait_done(60, n);
            check($sformatf("v%0d_edge", i), 32'(n), 32'(vecs[i].done_edge));
            check($sformatf("v%0d_pass", i), 32'(pass_o), 32'(vecs[i].pass_v));
            check($sformatf("v%0d_fail", i), 32'(fail_o), 32'(vecs[i].fail_v));
            check($sformatf("v%0d_step", i), 32'(fail_step_o), 32'(vecs[i].step_v));
            check($sformatf("v%0d_bits", i), 32'(fail_bits_o), 32'(vecs[i].bits_v));
            check($sformatf("v%0d_pcnt", i), 32'(pass_cnt_o), 32'(vecs[i].pcnt_v));
            check($sformatf("v%0d_pins", i), 32'(test_pins), 0);
            check($sformatf("v%0d_busy", i), 32'(busy_o), 0);
        end

        // Ideal run: pattern sequence per cycle, with an ignored start at edge 12.
        fault = F_NONE;
        do_reset();
        start_pulse();
        check("seq_k0", 32'(test_pins), 32'(exp_pat(0)));
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            start_i = (k == 12);
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (done_o) begin
                n = k;
                break;
            end
            check($sformatf("seq_k%0d", k), 32'(test_pins), 32'(exp_pat(k)));
            if (k == 12) check("start_busy_ignored", 32'(busy_o), 1);
        end
        check("seq_edge", 32'(n), 30);
        check("seq_pass", 32'(pass_o), 1);
        check("seq_pcnt", 32'(pass_cnt_o), 2);

        // Restart from DONE clears the previous results.
        fault = F_STUCK1_P3;
        start_pulse();
        check("restart_done", 32'(done_o), 0);
        check("restart_pass", 32'(pass_o), 0);
        check("restart_pcnt", 32'(pass_cnt_o), 0);
        check("restart_busy", 32'(busy_o), 1);
        wait_done(60, n);
        check("restart_fail_edge", 32'(n), 3);
        check("restart_fail", 32'(fail_o), 1);
        fault = F_NONE;
        start_pulse();
        check("restart2_fail", 32'(fail_o), 0);
        check("restart2_bits", 32'(fail_bits_o), 0);
        check("restart2_done", 32'(done_o), 0);
        wait_done(60, n);
        check("restart2_edge", 32'(n), 30);
        check("restart2_pass", 32'(pass_o), 1);

        // Abort and start together from DONE: start wins; then abort at edge 7.
        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_start_busy", 32'(busy_o), 1);
        check("abort_start_pins", 32'(test_pins), 4'b0001);
        for (int k = 1; k <= 7; k++) begin
            abort_i = (k == 7);
            @(posedge clk_i); #1;
        end
        abort_i = 1'b0;
        check_idle("abort7");
        repeat (10) @(posedge clk_i);
        #1;
        check("abort7_later_done", 32'(done_o), 0);

        // Abort in the same cycle as a SAMPLE mismatch: abort wins.
        fault = F_STUCK0_P2;
        do_reset();
        start_pulse();
        for (int k = 1; k <= 9; k++) begin
            abort_i = (k == 9);
            @(posedge clk_i); #1;
        end
        abort_i = 1'b0;
        check_idle("abort_vs_fail");
        repeat (5) @(posedge clk_i);
        #1;
        check("abort_vs_fail_later", 32'(done_o), 0);

        // Reset mid-run at edge 5.
        fault = F_NONE;
        do_reset();
        start_pulse();
        for (int k = 1; k <= 5; k++) begin
            rst_i = (k == 5);
            @(posedge clk_i); #1;
        end
        rst_i = 1'b0;
        check_idle("rst_mid");
        repeat (40) @(posedge clk_i);
        #1;
        check("rst_mid_later_done", 32'(done_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
